// File: rtl/first_stage_feeder_if.sv
// Bundle of first_stage_feeder control, memory-read and element-lane signals.
// master: the feeder itself; slave: the job controller / memory / consumer side.
interface first_stage_feeder_if #(
   parameter int unsigned ADDR_WIDTH = 8
);
   localparam int unsigned LANE_W = 16;
   localparam int unsigned DATA_W = 64;

   logic                     go;
   logic                     hold;
   logic [1:0]               quadrant_sel;
   logic [ADDR_WIDTH-1:0]    base_addr;
   logic                     mem_rd;
   logic [ADDR_WIDTH-1:0]    mem_addr;
   logic [DATA_W-1:0]        b_rdata;
   logic [DATA_W-1:0]        a_rdata;
   logic signed [LANE_W-1:0] b0_element;
   logic signed [LANE_W-1:0] b1_element;
   logic signed [LANE_W-1:0] b2_element;
   logic signed [LANE_W-1:0] b3_element;
   logic signed [LANE_W-1:0] a0_element;
   logic signed [LANE_W-1:0] a1_element;
   logic signed [LANE_W-1:0] a2_element;
   logic signed [LANE_W-1:0] a3_element;
   logic                     b_element_ready;
   logic                     a_element_ready;
   logic                     last_element;
   logic [1:0]               quadrant;
   logic                     busy;
   logic                     done;

   modport master (
      input  go, hold, quadrant_sel, base_addr, b_rdata, a_rdata,
      output mem_rd, mem_addr,
      output b0_element, b1_element, b2_element, b3_element,
      output a0_element, a1_element, a2_element, a3_element,
      output b_element_ready, a_element_ready, last_element,
      output quadrant, busy, done
   );

   modport slave (
      output go, hold, quadrant_sel, base_addr, b_rdata, a_rdata,
      input  mem_rd, mem_addr,
      input  b0_element, b1_element, b2_element, b3_element,
      input  a0_element, a1_element, a2_element, a3_element,
      input  b_element_ready, a_element_ready, last_element,
      input  quadrant, busy, done
   );
endinterface

// File: rtl/first_stage_feeder.sv
// first_stage_feeder: streams one vector four times (one pass per downstream
// layer) from memory into registered b/a element lanes, two cycles after each
// read. hold is honoured only between passes.
// Optional macro FIRST_STAGE_FEEDER_PASS_GAP_EN: one idle cycle between passes.
module first_stage_feeder #(
   parameter int unsigned VECTOR_LENGTH = 16,
   parameter int unsigned ADDR_WIDTH    = 8
) (
   input logic                  clock,
   input logic                  clear_n,
   first_stage_feeder_if.master bus
);
   localparam int unsigned IDX_W  = (VECTOR_LENGTH > 2) ? $clog2(VECTOR_LENGTH) : 1;
   localparam int unsigned PASS_W = 2;
   localparam int unsigned DATA_W = 64;

   typedef enum logic [1:0] {IDLE, STREAM, PAUSE, FINISH} state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [PASS_W-1:0]      pass_q, pass_d;
   logic [ADDR_WIDTH-1:0]  base_q, base_d;
   logic [1:0]             quad_q, quad_d;
   logic                   mem_rd_q, mem_rd_d;
   logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
   logic                   last_rd_q, last_rd_d;
   logic                   job_last_rd_q, job_last_rd_d;
   logic                   v1_q, v1_d;
   logic                   last1_q, last1_d;
   logic                   jl1_q, jl1_d;
   logic                   jl2_q, jl2_d;
   logic                   ready_q, ready_d;
   logic                   last_el_q, last_el_d;
   logic [DATA_W-1:0]      b_lane_q, b_lane_d;
   logic [DATA_W-1:0]      a_lane_q, a_lane_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   // Sequencer: the read issued in a STREAM cycle is element idx_q of pass_q.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pass_d  = pass_q;
      base_d  = base_q;
      quad_d  = quad_q;
      unique case (state_q)
         IDLE: begin
            if (bus.go) begin
               state_d = STREAM;
               idx_d   = '0;
               pass_d  = '0;
               base_d  = bus.base_addr;
               quad_d  = bus.quadrant_sel;
            end
         end
         STREAM: begin
            if (idx_q == IDX_W'(VECTOR_LENGTH - 1)) begin
               if (pass_q == PASS_W'(3)) begin
                  state_d = FINISH;
               end else begin
                  idx_d  = '0;
                  pass_d = pass_q + PASS_W'(1);
`ifdef FIRST_STAGE_FEEDER_PASS_GAP_EN
                  state_d = PAUSE;
`else
                  if (bus.hold) state_d = PAUSE;
`endif
               end
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         PAUSE: begin
            if (!bus.hold) state_d = STREAM;
         end
         FINISH: begin
            if (done_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Read strobe/address and read-side tags, registered from the next state.
   always_comb begin
      mem_rd_d      = (state_d == STREAM);
      mem_addr_d    = mem_rd_d ? (base_d + ADDR_WIDTH'(idx_d)) : mem_addr_q;
      last_rd_d     = mem_rd_d && (idx_d == IDX_W'(VECTOR_LENGTH - 1));
      job_last_rd_d = last_rd_d && (pass_d == PASS_W'(3));
      busy_d        = (state_d != IDLE);
   end

   // Two-stage element pipeline: rdata valid one cycle after the read, lanes one later.
   always_comb begin
      v1_d      = mem_rd_q;
      last1_d   = last_rd_q;
      jl1_d     = job_last_rd_q;
      ready_d   = v1_q;
      last_el_d = v1_q && last1_q;
      jl2_d     = v1_q && jl1_q;
      b_lane_d  = v1_q ? bus.b_rdata : '0;
      a_lane_d  = v1_q ? bus.a_rdata : '0;
      done_d    = (state_q == FINISH) && jl2_q;
   end

   // All state and outputs; reset aborts any job and zeroes every output.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         pass_q        <= '0;
         base_q        <= '0;
         quad_q        <= '0;
         mem_rd_q      <= 1'b0;
         mem_addr_q    <= '0;
         last_rd_q     <= 1'b0;
         job_last_rd_q <= 1'b0;
         v1_q          <= 1'b0;
         last1_q       <= 1'b0;
         jl1_q         <= 1'b0;
         jl2_q         <= 1'b0;
         ready_q       <= 1'b0;
         last_el_q     <= 1'b0;
         b_lane_q      <= '0;
         a_lane_q      <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         pass_q        <= pass_d;
         base_q        <= base_d;
         quad_q        <= quad_d;
         mem_rd_q      <= mem_rd_d;
         mem_addr_q    <= mem_addr_d;
         last_rd_q     <= last_rd_d;
         job_last_rd_q <= job_last_rd_d;
         v1_q          <= v1_d;
         last1_q       <= last1_d;
         jl1_q         <= jl1_d;
         jl2_q         <= jl2_d;
         ready_q       <= ready_d;
         last_el_q     <= last_el_d;
         b_lane_q      <= b_lane_d;
         a_lane_q      <= a_lane_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   // Output mapping.
   assign bus.mem_rd          = mem_rd_q;
   assign bus.mem_addr        = mem_addr_q;
   assign bus.b0_element      = b_lane_q[15:0];
   assign bus.b1_element      = b_lane_q[31:16];
   assign bus.b2_element      = b_lane_q[47:32];
   assign bus.b3_element      = b_lane_q[63:48];
   assign bus.a0_element      = a_lane_q[15:0];
   assign bus.a1_element      = a_lane_q[31:16];
   assign bus.a2_element      = a_lane_q[47:32];
   assign bus.a3_element      = a_lane_q[63:48];
   assign bus.b_element_ready = ready_q;
   assign bus.a_element_ready = ready_q;
   assign bus.last_element    = last_el_q;
   assign bus.quadrant        = quad_q;
   assign bus.busy            = busy_q;
   assign bus.done            = done_q;
endmodule

// File: tb/tb_first_stage_feeder.sv
// Directed bench for first_stage_feeder with VECTOR_LENGTH=4, default build.
// Cycle 0 is the cycle go is driven; outputs are sampled 1 time unit after each edge.
module tb_first_stage_feeder;
   localparam int unsigned VL = 4;
   localparam int unsigned AW = 8;

   logic clock;
   logic clear_n;
   int   errors = 0;
   int   checks = 0;

   first_stage_feeder_if #(.ADDR_WIDTH(AW)) bus ();

   first_stage_feeder #(.VECTOR_LENGTH(VL), .ADDR_WIDTH(AW)) dut (
      .clock   (clock),
      .clear_n (clear_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory: registered read data; b is constant, a tags each lane with the address.
   always @(posedge clock) begin
      if (bus.mem_rd) begin
         bus.b_rdata <= 64'h0004_0003_0002_0001;
         bus.a_rdata <= {8'hD0, bus.mem_addr, 8'hC0, bus.mem_addr,
                         8'hB0, bus.mem_addr, 8'hA0, bus.mem_addr};
      end else begin
         bus.b_rdata <= '1;
         bus.a_rdata <= '1;
      end
   end

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [159:0] all_outs();
      return {16'h0, bus.mem_rd, bus.mem_addr,
              bus.b3_element, bus.b2_element, bus.b1_element, bus.b0_element,
              bus.a3_element, bus.a2_element, bus.a1_element, bus.a0_element,
              bus.b_element_ready, bus.a_element_ready, bus.last_element,
              bus.quadrant, bus.busy, bus.done};
   endfunction

   // One job: st* = cycle of each pass's element-0 read, hold high over [hl,hh],
   // a second go at cycle 10 (busy, must be ignored), optional early exit at abort_c.
   task automatic run_job(input logic [7:0] base, input logic [1:0] qsel,
                          input int st0, input int st1, input int st2, input int st3,
                          input int done_c, input int hl, input int hh, input int abort_c);
      int st[4];
      logic rd, rdy;
      int ridx, eidx;
      logic [7:0] ra, ea;
      logic [63:0] exp_b, exp_a;
      st = '{st0, st1, st2, st3};
      bus.base_addr    = base;
      bus.quadrant_sel = qsel;
      bus.go           = 1'b1;
      bus.hold         = (hl <= 0 && hh >= 0);
      for (int c = 1; c <= done_c + 2; c++) begin
         @(posedge clock); #1;
         bus.go           = (c == 10);
         bus.base_addr    = base + 8'h40;
         bus.quadrant_sel = ~qsel;
         bus.hold         = (c >= hl && c <= hh);
         rd = 1'b0; rdy = 1'b0; ridx = 0; eidx = 0;
         for (int p = 0; p < 4; p++) begin
            if (c >= st[p] && c < st[p] + int'(VL)) begin rd = 1'b1; ridx = c - st[p]; end
            if (c - 2 >= st[p] && c - 2 < st[p] + int'(VL)) begin rdy = 1'b1; eidx = c - 2 - st[p]; end
         end
         ra = base + 8'(ridx);
         ea = base + 8'(eidx);
         exp_b = rdy ? 64'h0004_0003_0002_0001 : 64'h0;
         exp_a = rdy ? {8'hD0, ea, 8'hC0, ea, 8'hB0, ea, 8'hA0, ea} : 64'h0;
         chk("mem_rd", 160'(bus.mem_rd), 160'(rd));
         if (rd) chk("mem_addr", 160'(bus.mem_addr), 160'(ra));
         chk("b_ready", 160'(bus.b_element_ready), 160'(rdy));
         chk("a_ready", 160'(bus.a_element_ready), 160'(rdy));
         chk("last_element", 160'(bus.last_element), 160'(rdy && eidx == int'(VL) - 1));
         chk("b_lanes", 160'({bus.b3_element, bus.b2_element, bus.b1_element, bus.b0_element}), 160'(exp_b));
         chk("a_lanes", 160'({bus.a3_element, bus.a2_element, bus.a1_element, bus.a0_element}), 160'(exp_a));
         chk("done", 160'(bus.done), 160'(c == done_c));
         chk("busy", 160'(bus.busy), 160'(c <= done_c));
         chk("quadrant", 160'(bus.quadrant), 160'(qsel));
         if (c == abort_c) break;
      end
      bus.go   = 1'b0;
      bus.hold = 1'b0;
   endtask

   initial begin
      clear_n          = 1'b0;
      bus.go           = 1'b0;
      bus.hold         = 1'b0;
      bus.quadrant_sel = 2'd0;
      bus.base_addr    = 8'd0;
      #12;
      chk("reset_outputs", all_outs(), 160'h0);
      clear_n = 1'b1;
      @(posedge clock); #1;
      chk("idle_after_reset", all_outs(), 160'h0);

      // Plain job; hold over the end of pass 3 and over no boundary has no effect.
      run_job(8'd8, 2'd2, 1, 5, 9, 13, 19, 13, 20, -1);

      // hold from cycle 2, released before the edge that opens cycle 8: pause after pass 0.
      run_job(8'd8, 2'd1, 1, 8, 12, 16, 22, 2, 6, -1);

      // Address wrap at 255->0; hold mid-pass 1 only; hold at go ignored by pass 0.
      run_job(8'd254, 2'd3, 1, 5, 9, 13, 19, 5, 7, -1);
      run_job(8'd254, 2'd0, 1, 5, 9, 13, 19, 0, 0, -1);

      // Abort at cycle 10: asynchronous clear zeroes everything at once.
      run_job(8'd8, 2'd1, 1, 5, 9, 13, 19, -5, -5, 10);
      #1 clear_n = 1'b0;
      #1 chk("async_clear_outputs", all_outs(), 160'h0);
      @(posedge clock); @(posedge clock); #1;
      clear_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         chk("no_done_after_abort", {all_outs()[159:2], 2'b00}, 160'h0);
         chk("done_after_abort", 160'(bus.done), 160'h0);
         @(posedge clock); #1;
      end

      // Restart after abort begins again at pass 0.
      run_job(8'd8, 2'd2, 1, 5, 9, 13, 19, -5, -5, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/first_stage_feeder.md
FIRST_STAGE_FEEDER -- requirements
Module: first_stage_feeder

Interface
REQ-001 Parameter VECTOR_LENGTH, 16, elements per vector; legal range 2-256.
REQ-002 Parameter ADDR_WIDTH, 8, width of the memory address bus.
REQ-003 clock  in  1  single clock for all state; all state changes on the rising edge.
REQ-004 clear_n  in  1  reset, asynchronous and active-low.
REQ-005 go  in  1  start request; sampled only in IDLE.
REQ-006 hold  in  1  pause request; honoured only at pass boundaries.
REQ-007 quadrant_sel  in  2  quadrant select, captured on an accepted go.
REQ-008 base_addr  in  ADDR_WIDTH  vector start address, captured on an accepted go.
REQ-009 mem_rd  out  1  read strobe.
REQ-010 mem_addr  out  ADDR_WIDTH  read address.
REQ-011 b_rdata  in  64  read data: b0 in [15:0], b1 in [31:16], b2 in [47:32], b3 in [63:48]; valid 1 cycle after mem_rd.
REQ-012 a_rdata  in  64  a0-a3 in the same lane order; shares mem_addr and mem_rd.
REQ-013 b0_element..b3_element, a0_element..a3_element  out  16 each, signed  element lanes.
REQ-014 b_element_ready, a_element_ready  out  1 each  element-valid strobes; always equal.
REQ-015 last_element  out  1  final element of the current pass.
REQ-016 quadrant  out  2  captured quadrant_sel.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle completion pulse.

Function
REQ-019 The FSM states SHALL be IDLE, STREAM, PAUSE and FINISH.
REQ-020 IDLE->STREAM on go=1, capturing base_addr and quadrant_sel; go while busy SHALL be ignored.
REQ-021 A job SHALL be 4 passes (pass 0-3, one per downstream layer), each of VECTOR_LENGTH elements.
REQ-022 Element i of every pass SHALL be read from address base_addr+i, with addition mod 2^ADDR_WIDTH (wraps).
REQ-023 In STREAM, mem_rd SHALL be high every cycle, one element per cycle.
REQ-024 Element lanes and ready strobes SHALL be registered from rdata, so each element is presented exactly 2 cycles after its read is issued.
REQ-025 Within a pass, ready SHALL stay high on consecutive cycles; no bubble SHALL occur mid-vector.
REQ-026 last_element SHALL be high only together with ready, on element VECTOR_LENGTH-1 of each pass.
REQ-027 hold SHALL be sampled only when the next read would be element 0 of pass 1, 2 or 3.
REQ-028 If hold=1 at that point: enter PAUSE, with mem_rd=0 and no new reads; elements already issued SHALL still drain.
REQ-029 PAUSE->STREAM on the first cycle hold=0.
REQ-030 hold high at any other time SHALL have no effect.
REQ-031 After the last read of pass 3, go to FINISH.
REQ-032 In FINISH, done SHALL pulse high for 1 cycle, the cycle after pass 3's last_element; the next state SHALL be IDLE.
REQ-033 When ready=0, all lane outputs and last_element SHALL be 0.

Reset
REQ-034 clear_n=0 SHALL immediately force IDLE and clear all counters.
REQ-035 clear_n=0 SHALL immediately force all outputs to 0, including mem_addr, quadrant and the lanes.
REQ-036 Reset mid-job SHALL abort the job with no done pulse.
REQ-037 After clear_n rises, the first cycle SHALL be IDLE.

Configuration
REQ-038 Macro FIRST_STAGE_FEEDER_PASS_GAP_EN defined: exactly one idle cycle (mem_rd=0, ready=0) SHALL be inserted between consecutive passes, in addition to any PAUSE cycles.
REQ-039 Macro FIRST_STAGE_FEEDER_PASS_GAP_EN undefined: passes SHALL run back-to-back with no gap unless hold intervenes.

Verification (VECTOR_LENGTH=4, macro undefined unless stated)
REQ-040 go at cycle 0, base_addr=8, hold=0 -> mem_addr 8,9,10,11 repeated 4 times starting cycle 1; ready high cycles 3-18; last_element at cycles 6, 10, 14, 18; done at cycle 19.
REQ-041 b_rdata=0x0004_0003_0002_0001 on every read -> b0..b3_element = 1,2,3,4 whenever ready.
REQ-042 Same run with hold=1 from cycle 2 until cycle 8 -> 0 effect in pass 0; reads pause after pass 0; reads resume cycle 8; ready low for the gap; total of 16 ready cycles.
REQ-043 base_addr=254, ADDR_WIDTH=8 -> addresses 254, 255, 0, 1 per pass.
REQ-044 clear_n low at cycle 10 -> outputs are 0 at once; no done pulse; go after release restarts at pass 0.
REQ-045 Macro defined -> one ready-low cycle between passes; done at cycle 22.
